// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, symbol width, receiver FSM states and bit-slip helper
package tmds_pkg;
  localparam int SYM_W = 10;
  localparam logic [SYM_W-1:0] TOK_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOK_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOK_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOK_11 = 10'b1010101011;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} rx_state_t;
  function automatic logic [3:0] next_offset(input logic [3:0] o);
    return (o == 4'd9) ? 4'd0 : o + 4'd1;
  endfunction
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational TMDS symbol decoder (q -> is_token, ctrl {C1,C0}, data byte)
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] q,
  output logic             is_token,
  output logic [1:0]       ctrl,
  output logic [7:0]       data
);
  logic [7:0] p;
  assign p = q[9] ? ~q[7:0] : q[7:0];
  assign data = {p[7:1] ^ p[6:0] ^ {7{~q[8]}}, p[0]};
  assign is_token = (q == TOK_00) || (q == TOK_01) || (q == TOK_10) || (q == TOK_11);
  assign ctrl = (q == TOK_01) ? 2'b01 : (q == TOK_10) ? 2'b10 : (q == TOK_11) ? 2'b11 : 2'b00;
endmodule

// File: rtl/tmds_rx_channel.sv
// tmds_rx_channel: TMDS channel receiver; i_sym raw words in, word alignment by token hunting, o_data/o_de/o_ctrl/o_locked/o_offset out
module tmds_rx_channel
  import tmds_pkg::*;
#(
  parameter int TIMEOUT     = 4096,
  parameter int LOCK_TOKENS = 8
) (
  input  logic             i_pixclk,
  input  logic             i_reset,
  input  logic [SYM_W-1:0] i_sym,
  output logic [7:0]       o_data,
  output logic             o_de,
  output logic [1:0]       o_ctrl,
  output logic             o_locked,
  output logic [3:0]       o_offset
);
  localparam int IW = $clog2(TIMEOUT);
  localparam int RW = $clog2(LOCK_TOKENS + 1);
  logic [SYM_W-1:0] r_prev, r_cur, win;
  logic [2*SYM_W-1:0] cat;
  rx_state_t state;
  logic [IW-1:0] idle;
  logic [RW-1:0] run;
  logic tok, idle_max, slip, lock_nxt;
  logic [1:0] tctrl;
  logic [7:0] tdata;
  assign cat = {r_cur, r_prev};
  assign win = SYM_W'(cat >> o_offset);
  tmds_symbol_decode u_dec (
    .q        (win),
    .is_token (tok),
    .ctrl     (tctrl),
    .data     (tdata)
  );
  assign idle_max = idle == IW'(TIMEOUT - 1);
  assign slip = (state == VERIFY) ? !tok : !tok && idle_max;
  assign lock_nxt = (state == VERIFY && tok && run == RW'(LOCK_TOKENS - 1)) || (state == LOCKED && !slip);
  always_ff @(posedge i_pixclk or posedge i_reset) begin
    if (i_reset) begin
      r_prev   <= '0;
      r_cur    <= '0;
      state    <= SEARCH;
      idle     <= '0;
      run      <= '0;
      o_offset <= '0;
      o_data   <= '0;
      o_de     <= 1'b0;
      o_ctrl   <= '0;
      o_locked <= 1'b0;
    end else begin
      r_prev   <= r_cur;
      r_cur    <= i_sym;
      state    <= lock_nxt ? LOCKED : (tok && state != LOCKED) ? VERIFY : SEARCH;
      idle     <= (tok || slip || state == VERIFY) ? '0 : idle + 1'b1;
      run      <= (tok && state != LOCKED) ? run + 1'b1 : '0;
      o_offset <= slip ? next_offset(o_offset) : o_offset;
      o_locked <= lock_nxt;
      o_de     <= lock_nxt && !tok;
      o_data   <= (lock_nxt && !tok) ? tdata : '0;
      o_ctrl   <= !lock_nxt ? '0 : tok ? tctrl : o_ctrl;
    end
  end
endmodule

// File: tb/tb_tmds_rx_channel.sv
// tb_tmds_rx_channel: directed self-checking bench for tmds_rx_channel with TIMEOUT=64, LOCK_TOKENS=8
module tb_tmds_rx_channel;
  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] D55 = 10'h133;
  localparam logic [9:0] D00 = 10'h255;
  localparam logic [9:0] DFF = 10'h200;
  localparam logic [9:0] DA5 = 10'h163;
  localparam logic [9:0] D44 = 10'h3C3;
  localparam logic [9:0] DEE = 10'h0F0;
  logic i_pixclk = 1'b0;
  logic i_reset = 1'b1;
  logic [9:0] i_sym = '0;
  logic [7:0] o_data;
  logic o_de;
  logic [1:0] o_ctrl;
  logic o_locked;
  logic [3:0] o_offset;
  int checks = 0;
  int fails = 0;
  int rot = 0;
  logic [9:0] last_sym = '0;
  tmds_rx_channel #(.TIMEOUT(64), .LOCK_TOKENS(8)) dut (
    .i_pixclk (i_pixclk),
    .i_reset  (i_reset),
    .i_sym    (i_sym),
    .o_data   (o_data),
    .o_de     (o_de),
    .o_ctrl   (o_ctrl),
    .o_locked (o_locked),
    .o_offset (o_offset)
  );
  always #5 i_pixclk = ~i_pixclk;
  task automatic send(input logic [9:0] s);
    logic [19:0] c;
    c = {s, last_sym};
    i_sym = 10'(c >> (10 - rot));
    last_sym = s;
    @(posedge i_pixclk);
    #1;
  endtask
  task automatic do_reset(input int r);
    i_reset = 1'b1;
    i_sym = '0;
    rot = r;
    last_sym = D55;
    @(posedge i_pixclk);
    #1;
    i_reset = 1'b0;
  endtask
  task automatic test_reset;
    @(posedge i_pixclk);
    #1;
    checks++;
    if ({o_data, o_de, o_ctrl, o_locked, o_offset} !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: got %h expected 0000", {o_data, o_de, o_ctrl, o_locked, o_offset});
    end
  endtask
  task automatic test_aligned_lock;
    do_reset(0);
    for (int k = 1; k <= 16; k++) begin
      send(T00);
      if (k == 9) begin
        checks++;
        if (o_locked !== 1'b0) begin fails++; $display("FAIL lock_early: locked %b expected 0 after 7 tokens", o_locked); end
      end
      if (k == 10) begin
        checks++;
        if ({o_locked, o_de, o_ctrl, o_offset} !== 8'b1_0_00_0000) begin
          fails++;
          $display("FAIL lock_8th: locked/de/ctrl/offset %b expected 10000000", {o_locked, o_de, o_ctrl, o_offset});
        end
      end
    end
    send(D55);
    send(D55);
    checks++;
    if (o_de !== 1'b0) begin fails++; $display("FAIL data_latency_early: de %b expected 0", o_de); end
    send(D55);
    checks++;
    if ({o_de, o_data, o_ctrl} !== {1'b1, 8'h55, 2'b00}) begin
      fails++;
      $display("FAIL data_55: de %b data %h ctrl %b expected de 1 data 55 ctrl 00", o_de, o_data, o_ctrl);
    end
  endtask
  task automatic test_four_tokens;
    logic [9:0] s [7] = '{T00, T01, T10, T11, D44, DEE, D55};
    logic [10:0] e [7] = '{{1'b0, 2'b00, 8'h00}, {1'b0, 2'b01, 8'h00}, {1'b0, 2'b10, 8'h00}, {1'b0, 2'b11, 8'h00},
                          {1'b1, 2'b11, 8'h44}, {1'b1, 2'b11, 8'hEE}, {1'b1, 2'b11, 8'h55}};
    for (int i = 0; i < 9; i++) begin
      send(i < 7 ? s[i] : D55);
      if (i >= 2) begin
        checks++;
        if ({o_de, o_ctrl, o_data} !== e[i-2] || o_locked !== 1'b1) begin
          fails++;
          $display("FAIL tokens_seq[%0d]: de/ctrl/data %h locked %b expected %h locked 1", i - 2, {o_de, o_ctrl, o_data}, o_locked, e[i-2]);
        end
      end
    end
  endtask
  task automatic test_timeout_loss;
    send(T00);
    for (int k = 1; k <= 300; k++) begin
      send(D55);
      if (k == 65) begin
        checks++;
        if ({o_locked, o_de, o_data} !== {1'b1, 1'b1, 8'h55}) begin
          fails++;
          $display("FAIL loss_early: locked %b de %b data %h expected 1 1 55", o_locked, o_de, o_data);
        end
      end
      if (k == 66) begin
        checks++;
        if ({o_locked, o_de, o_ctrl, o_data, o_offset} !== {4'b0000, 8'h00, 4'd1}) begin
          fails++;
          $display("FAIL loss_64: locked %b de %b ctrl %b data %h offset %0d expected 0 0 00 00 1", o_locked, o_de, o_ctrl, o_data, o_offset);
        end
      end
    end
    checks++;
    if ({o_locked, o_offset} !== {1'b0, 4'd4}) begin
      fails++;
      $display("FAIL search_slips: locked %b offset %0d expected 0 4", o_locked, o_offset);
    end
  endtask
  task automatic test_rotated;
    logic [9:0] s [3] = '{D00, DFF, DA5};
    logic [7:0] e [3] = '{8'h00, 8'hFF, 8'hA5};
    int c;
    do_reset(3);
    c = 0;
    while (!o_locked && c < 12000) begin
      send((c % 200) < 100 ? D55 : T00);
      c++;
    end
    checks++;
    if ({o_locked, o_offset} !== {1'b1, 4'd3}) begin
      fails++;
      $display("FAIL rot3_lock: locked %b offset %0d expected 1 3", o_locked, o_offset);
    end
    for (int i = 0; i < 5; i++) begin
      send(i < 3 ? s[i] : D55);
      if (i >= 2) begin
        checks++;
        if ({o_de, o_data} !== {1'b1, e[i-2]}) begin
          fails++;
          $display("FAIL rot3_data[%0d]: de %b data %h expected 1 %h", i - 2, o_de, o_data, e[i-2]);
        end
      end
    end
  endtask
  task automatic test_wrap;
    logic [3:0] prev, exp_off;
    int last_c, c;
    bit wrapped;
    do_reset(9);
    prev = 4'd0;
    last_c = 0;
    wrapped = 1'b0;
    for (int k = 1; k <= 800 && !wrapped; k++) begin
      send(D55);
      if (o_offset !== prev) begin
        exp_off = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
        checks++;
        if (o_offset !== exp_off) begin fails++; $display("FAIL wrap_step: offset %0d expected %0d", o_offset, exp_off); end
        checks++;
        if (k - last_c != 64) begin fails++; $display("FAIL slip_interval: %0d cycles expected 64", k - last_c); end
        wrapped = (prev == 4'd9);
        prev = o_offset;
        last_c = k;
      end
    end
    checks++;
    if (!wrapped) begin fails++; $display("FAIL wrap_seen: offset %0d never wrapped 9 to 0", o_offset); end
    c = 0;
    while (!o_locked && c < 1000) begin
      send(T00);
      c++;
    end
    checks++;
    if ({o_locked, o_offset} !== {1'b1, 4'd9}) begin
      fails++;
      $display("FAIL rot9_lock: locked %b offset %0d expected 1 9", o_locked, o_offset);
    end
  endtask
  task automatic test_reset_mid_lock;
    send(T00);
    send(T00);
    checks++;
    if (o_locked !== 1'b1) begin fails++; $display("FAIL pre_reset_lock: locked %b expected 1", o_locked); end
    #2;
    i_reset = 1'b1;
    #1;
    checks++;
    if ({o_data, o_de, o_ctrl, o_locked, o_offset} !== 16'h0) begin
      fails++;
      $display("FAIL async_reset: got %h expected 0000", {o_data, o_de, o_ctrl, o_locked, o_offset});
    end
    @(posedge i_pixclk);
    #1;
    i_reset = 1'b0;
    rot = 0;
    for (int k = 1; k <= 10; k++) begin
      send(T00);
      if (k == 9) begin
        checks++;
        if (o_locked !== 1'b0) begin fails++; $display("FAIL relock_early: locked %b expected 0", o_locked); end
      end
    end
    checks++;
    if ({o_locked, o_offset} !== {1'b1, 4'd0}) begin
      fails++;
      $display("FAIL relock: locked %b offset %0d expected 1 0", o_locked, o_offset);
    end
  endtask
  initial begin
    test_reset;
    test_aligned_lock;
    test_four_tokens;
    test_timeout_loss;
    test_rotated;
    test_wrap;
    test_reset_mid_lock;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
